dsp_result_collector: RTL

Consumer-side companion to the DSP48A1 pipeline registers. It tracks every operand set issued into the slice, delays an issue marker by the configured pipeline latency, and captures the P/CARRYOUT result exactly when it emerges. Captured results go into a small FIFO with a valid/ready output. Issue credit is throttled so that a result is never produced without FIFO space to hold it.

---
 rtl/dsp_result_collector.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dsp_result_collector.sv
// dsp_result_collector
// Tracks operand sets issued into a DSP48A1 slice, delays an issue marker by
// the slice pipeline latency and captures {CARRYOUT, P} when the result
// emerges. Results are queued in a small FIFO with a valid/ready output.
// Issue credit is throttled so every result in flight already owns a slot.
module dsp_result_collector #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [WIDTH-1:0]           p_in,
    input  logic                       carry_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_carry,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);

    // Registered state
    logic [LATENCY-1:0] marker_r;
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      count_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [WIDTH:0]     mem_r [DEPTH];
    logic               issue_ready_r;
    logic               out_valid_r;
    logic               err_r;

    // Per-cycle events and next-state values
    logic               accept_s;
    logic               capture_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_en_s;
    logic               overflow_s;
    logic [CW-1:0]      inflight_nxt_s;
    logic [CW-1:0]      count_nxt_s;
    logic [CW:0]        credit_sum_s;
    logic               ready_nxt_s;
    logic [WIDTH:0]     head_s;

    // Decode handshakes and compute next occupancy and credit
    always_comb begin
        accept_s       = issue_valid && issue_ready_r;
        capture_s      = marker_r[LATENCY-1];
        pop_s          = out_valid_r && out_ready;
        full_s         = (count_r == DEPTH_C);
        // At full a same-cycle pop frees the slot being overwritten
        wr_en_s        = capture_s && (!full_s || pop_s);
        overflow_s     = capture_s && full_s && !pop_s;
        inflight_nxt_s = inflight_r;
        count_nxt_s    = count_r;

        if (accept_s && !capture_s) begin
            inflight_nxt_s = inflight_r + CNT_ONE_C;
        end else if (capture_s && !accept_s) begin
            inflight_nxt_s = inflight_r - CNT_ONE_C;
        end else begin
            inflight_nxt_s = inflight_r;
        end

        if (wr_en_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE_C;
        end else if (pop_s && !wr_en_s) begin
            count_nxt_s = count_r - CNT_ONE_C;
        end else begin
            count_nxt_s = count_r;
        end

        credit_sum_s = {1'b0, count_nxt_s} + {1'b0, inflight_nxt_s};
        ready_nxt_s  = (credit_sum_s < DEPTH_W_C);
    end

    // Marker pipe: one bit per accepted issue, aligned with the slice latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            marker_r <= {LATENCY{1'b0}};
        end else if (flush) begin
            marker_r <= {LATENCY{1'b0}};
        end else begin
            marker_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
                marker_r[i] <= marker_r[i-1];
            end
        end
    end

    // Occupancy counters, pointers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            issue_ready_r <= 1'b1;
            out_valid_r   <= 1'b0;
        end else if (flush) begin
            inflight_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            issue_ready_r <= 1'b1;
            out_valid_r   <= 1'b0;
        end else begin
            inflight_r    <= inflight_nxt_s;
            count_r       <= count_nxt_s;
            // Pointers wrap naturally because DEPTH is a power of two
            wr_ptr_r      <= wr_en_s ? (wr_ptr_r + PTR_ONE_C) : wr_ptr_r;
            rd_ptr_r      <= pop_s ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
            issue_ready_r <= ready_nxt_s;
            out_valid_r   <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Result storage: capture {carry, P} at the write pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(WIDTH + 1){1'b0}};
            end
        end else if (wr_en_s && !flush) begin
            mem_r[wr_ptr_r] <= {carry_in, p_in};
        end else begin
            mem_r <= mem_r;
        end
    end

    // Sticky overflow flag; only a hard reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (overflow_s && !flush) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Head of FIFO, forced to zero when empty so no stale data is visible
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (out_valid_r) begin
            out_data  = head_s[WIDTH-1:0];
            out_carry = head_s[WIDTH];
        end else begin
            out_data  = {WIDTH{1'b0}};
            out_carry = 1'b0;
        end
    end

    assign issue_ready = issue_ready_r;
    assign out_valid   = out_valid_r;
    assign inflight    = inflight_r;
    assign err         = err_r;

endmodule
